// File: rtl/spi_rom_reader.sv
// spi_rom_reader: boot-ROM longword reads from SPI NOR flash, with chip-select hold for streaming and a one-longword cache
module spi_rom_reader #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter int IDLE_HOLD = 64,
  parameter int CS_HIGH_MIN = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rom_req,
  input  logic        READ,
  input  logic [21:0] ADDR,
  output logic [31:0] DOUT,
  output logic        rom_dtack,
  output logic        busy,
  output logic        SPI_CLK,
  output logic        SPI_MOSI,
  output logic        SPI_CS_n,
  input  logic        SPI_MISO
);
  typedef enum logic [2:0] {IDLE, CSHI, SHIFT, ACK, HOLD} state_t;
  state_t state;
  logic [21:0] next_addr, cache_addr, req_addr;
  logic next_valid, cache_valid, served, cold_pend, was_wr;
  logic [63:0] tx;
  logic [31:0] sh;
  logic [6:0] bits_left;
  logic [7:0] hi_cnt, hold_cnt;
  logic take, hit, seq, hi_ok, hold_out;
  always_comb begin
    take = (state == IDLE || state == HOLD) && rom_req && !served;
    hit = cache_valid && ADDR == cache_addr;
    seq = state == HOLD && next_valid && ADDR == next_addr;
    hi_ok = hi_cnt >= 8'(CS_HIGH_MIN);
    hold_out = state == HOLD && hold_cnt == 8'(IDLE_HOLD - 1);
  end
  assign busy = ~SPI_CS_n;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      SPI_CS_n <= 1'b1;
      SPI_CLK <= 1'b0;
      SPI_MOSI <= 1'b0;
      rom_dtack <= 1'b0;
      DOUT <= '0;
      sh <= '0;
      tx <= '0;
      cache_valid <= 1'b0;
      cache_addr <= '0;
      next_addr <= '0;
      next_valid <= 1'b0;
      req_addr <= '0;
      served <= 1'b0;
      cold_pend <= 1'b0;
      was_wr <= 1'b0;
      bits_left <= '0;
      hold_cnt <= '0;
      hi_cnt <= 8'(CS_HIGH_MIN);
    end else begin
      served <= rom_req && (served || take);
      hi_cnt <= SPI_CS_n ? hi_cnt + 8'(hi_cnt != 8'hFF) : 8'd0;
      hold_cnt <= hold_cnt + 8'd1;
      case (state)
        IDLE, HOLD: begin
          if (take) begin
            req_addr <= ADDR;
            was_wr <= !READ;
            tx <= {READ_CMD, ADDR, 2'b00, 32'd0};
            bits_left <= 7'd64;
            cold_pend <= 1'b1;
            if (!READ || hit) state <= ACK;
            else if (seq) begin
              tx <= '0;
              bits_left <= 7'd32;
              state <= SHIFT;
            end else if (state == HOLD) begin
              SPI_CS_n <= 1'b1;
              state <= CSHI;
            end else state <= hi_ok ? SHIFT : CSHI;
          end else if (hold_out) begin
            SPI_CS_n <= 1'b1;
            cold_pend <= 1'b0;
            state <= CSHI;
          end
        end
        CSHI: if (hi_ok) state <= cold_pend ? SHIFT : IDLE;
        SHIFT: begin
          if (SPI_CS_n) begin
            SPI_CS_n <= 1'b0;
            SPI_MOSI <= tx[63];
            tx <= {tx[62:0], 1'b0};
          end else if (!SPI_CLK) begin
            SPI_CLK <= 1'b1;
            if (bits_left <= 7'd32) sh <= {sh[30:0], SPI_MISO};
          end else begin
            SPI_CLK <= 1'b0;
            SPI_MOSI <= tx[63];
            tx <= {tx[62:0], 1'b0};
            bits_left <= bits_left - 7'd1;
            if (bits_left == 7'd1) begin
              cache_addr <= req_addr;
              cache_valid <= 1'b1;
              next_addr <= req_addr + 22'd1;
              next_valid <= ~&req_addr;
              hold_cnt <= '0;
              state <= (rom_req && served) ? ACK : HOLD;
            end
          end
        end
        ACK: begin
          if (rom_req && served) begin
            rom_dtack <= 1'b1;
            if (!rom_dtack && !was_wr) DOUT <= sh;
          end else begin
            rom_dtack <= 1'b0;
            hold_cnt <= '0;
            cold_pend <= 1'b0;
            state <= SPI_CS_n ? CSHI : HOLD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rom_reader.sv
// tb_spi_rom_reader: randomized and directed checks of spi_rom_reader against a flash model and a transaction-level reference
module tb_spi_rom_reader;
  localparam int CS_HIGH_MIN = 2;
  localparam int IDLE_HOLD = 64;
  logic CLK = 0, RST = 1, rom_req = 0, READ = 0, SPI_MISO = 0;
  logic [21:0] ADDR = '0;
  logic [31:0] DOUT;
  logic rom_dtack, busy, SPI_CLK, SPI_MOSI, SPI_CS_n;
  int errors = 0, checks = 0;
  int sclk_rises = 0, cs_falls = 0, cs_rises = 0, dtack_rises = 0, fbit = 0, fi = 0;
  logic [7:0] fb;
  logic [31:0] fcmd = '0, last_cmd = '0;
  logic m_cs_low = 0, m_cvalid = 0, m_next_ok = 0;
  logic [21:0] m_next = '0, m_caddr = '0;
  logic [31:0] m_dout = '0;

  spi_rom_reader #(.READ_CMD(8'h03), .IDLE_HOLD(IDLE_HOLD), .CS_HIGH_MIN(CS_HIGH_MIN)) dut (
    .CLK(CLK), .RST(RST), .rom_req(rom_req), .READ(READ), .ADDR(ADDR), .DOUT(DOUT),
    .rom_dtack(rom_dtack), .busy(busy), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_CS_n(SPI_CS_n), .SPI_MISO(SPI_MISO));

  always #20 CLK = ~CLK;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h40: return 8'hDE;
      24'h41: return 8'hAD;
      24'h42: return 8'hBE;
      24'h43: return 8'hEF;
      default: return 8'(a[7:0] * 8'd37) ^ 8'(a[15:8] * 8'd11) ^ a[23:16] ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [21:0] a);
    logic [23:0] b;
    b = {a, 2'b00};
    return {fbyte(b), fbyte(b + 24'd1), fbyte(b + 24'd2), fbyte(b + 24'd3)};
  endfunction

  // SPI NOR model: 8-bit command + 24-bit address, then bytes stream from that address while CS stays low
  always @(negedge SPI_CS_n) begin
    cs_falls++;
    fbit = 0;
  end
  always @(posedge SPI_CS_n) cs_rises++;
  always @(posedge rom_dtack) dtack_rises++;
  always @(posedge SPI_CLK) if (SPI_CS_n === 1'b0) begin
    sclk_rises++;
    if (fbit < 32) fcmd = {fcmd[30:0], SPI_MOSI};
    if (fbit == 31) last_cmd = fcmd;
    fbit++;
  end
  always @(negedge SPI_CLK) if (SPI_CS_n === 1'b0 && fbit >= 32) begin
    fi = fbit - 32;
    fb = fbyte(fcmd[23:0] + 24'(fi / 8));
    SPI_MISO = fb[7 - fi % 8];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic rd, input logic [21:0] a, input int gap);
    int lat, exp_lat, r0, f0, c0;
    exp_lat = !rd ? 1 : (m_cvalid && a == m_caddr) ? 1 :
              (m_cs_low && m_next_ok && a == m_next) ? 65 : m_cs_low ? 131 + CS_HIGH_MIN : 130;
    r0 = sclk_rises;
    f0 = cs_falls;
    c0 = cs_rises;
    @(negedge CLK);
    rom_req = 1;
    READ = rd;
    ADDR = a;
    @(posedge CLK);
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!rom_dtack && lat < 400);
    if (rd && exp_lat != 1) begin
      m_caddr = a;
      m_cvalid = 1;
      m_next = a + 22'd1;
      m_next_ok = a != '1;
      m_cs_low = 1;
    end
    if (rd) m_dout = word(a);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " DOUT"}, DOUT, m_dout);
    check({tag, " sclk edges"}, sclk_rises - r0, exp_lat == 1 ? 0 : exp_lat == 65 ? 32 : 64);
    check({tag, " cs falls"}, cs_falls - f0, exp_lat > 65 ? 1 : 0);
    check({tag, " cs rises"}, cs_rises - c0, exp_lat > 130 ? 1 : 0);
    if (exp_lat > 65) check({tag, " cmd"}, last_cmd, {8'h03, a, 2'b00});
    @(negedge CLK);
    rom_req = 0;
    @(posedge CLK);
    #1;
    check({tag, " dtack clear"}, rom_dtack, 0);
    repeat (gap) @(posedge CLK);
    if (gap > IDLE_HOLD + CS_HIGH_MIN + 8) m_cs_low = 0;
  endtask

  task automatic abort_read(input logic [21:0] a);
    int d0, r0;
    d0 = dtack_rises;
    r0 = sclk_rises;
    @(negedge CLK);
    rom_req = 1;
    READ = 1;
    ADDR = a;
    @(posedge CLK);
    repeat (40) @(posedge CLK);
    @(negedge CLK);
    rom_req = 0;
    ADDR = 22'($urandom);
    repeat (120) @(posedge CLK);
    #1;
    check("abort no dtack", dtack_rises - d0, 0);
    check("abort completes", sclk_rises - r0, 64);
    check("abort cs held", busy, 1);
    m_caddr = a;
    m_cvalid = 1;
    m_next = a + 22'd1;
    m_next_ok = a != '1;
    m_cs_low = 1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " CS_n"}, SPI_CS_n, 1);
    check({tag, " SPI_CLK"}, SPI_CLK, 0);
    check({tag, " dtack"}, rom_dtack, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " DOUT"}, DOUT, 0);
  endtask

  initial begin
    logic [21:0] a;
    int sel, gap;
    repeat (3) @(posedge CLK);
    #1;
    check_idle_outputs("reset");
    check("reset MOSI", SPI_MOSI, 0);
    @(negedge CLK);
    RST = 0;
    repeat (3) @(posedge CLK);

    run("cold 0x10", 1, 22'h10, 5);
    check("cold 0x10 word", DOUT, 32'hDEADBEEF);
    check("cold 0x10 mosi", last_cmd, 32'h03000040);
    run("seq 0x11", 1, 22'h11, 3);
    run("hit 0x11", 1, 22'h11, 0);
    repeat (63) @(posedge CLK);
    #1;
    check("hold before timeout", SPI_CS_n, 0);
    @(posedge CLK);
    #1;
    check("hold timeout", SPI_CS_n, 1);
    m_cs_low = 0;
    repeat (10) @(posedge CLK);
    run("cold 0x12", 1, 22'h12, 5);
    run("write", 0, 22'h12, 5);
    run("hit after write", 1, 22'h12, 5);
    abort_read(22'h2345);
    run("hit after abort", 1, 22'h2345, 5);
    run("top 0x3FFFFF", 1, 22'h3FFFFF, 5);
    run("wrap 0x0", 1, 22'h0, 5);
    check("wrap mosi", last_cmd, 32'h03000000);

    a = 22'($urandom);
    @(negedge CLK);
    rom_req = 1;
    READ = 1;
    ADDR = a;
    @(posedge CLK);
    repeat (70) @(posedge CLK);
    @(negedge CLK);
    RST = 1;
    @(posedge CLK);
    #1;
    check_idle_outputs("mid reset");
    @(negedge CLK);
    RST = 0;
    rom_req = 0;
    m_cvalid = 0;
    m_cs_low = 0;
    m_next_ok = 0;
    m_dout = '0;
    repeat (5) @(posedge CLK);
    run("after reset", 1, a, 5);

    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 3);
      a = sel == 0 ? m_next : sel == 1 ? m_caddr :
          sel == 2 ? m_caddr + 22'($urandom_range(1, 3)) : 22'($urandom);
      gap = $urandom_range(0, 3) == 0 ? $urandom_range(80, 110) : $urandom_range(2, 40);
      run("rand", $urandom_range(0, 4) != 0, a, gap);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
